hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the five-stage CPU.
- Detects load-use hazards that the EXE-stage forwarding path cannot cover, and squashes wrong-path instructions on a taken branch.
- Freezes the whole pipeline while a multi-cycle data-memory access is outstanding.
- Drives the PC and pipeline-register write-enable and flush controls; sits beside the forwarding unit in the top-level CPU.

Parameters:
- MEM_TIMEOUT, 15: maximum consecutive cycles waiting on mem_ready before entering ERR; legal range 1..255.

Ports:
- CLK  in  1  pipeline clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs1  in  5  ID source register 1
- id_rs2  in  5  ID source register 2
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_Mwk  in  1  EX stage holds a real instruction
- ex_RegWr  in  1  EX instruction writes a register
- ex_RegDst  in  2  EX writeback source; 2'b01 = data memory (load)
- ex_rd  in  5  EX destination register
- ex_branch_taken  in  1  EX resolved a taken branch or jump
- mem_req  in  1  MEM stage is performing a load or store
- mem_ready  in  1  data memory completes the access this cycle
- PCWre  out  1  PC write enable
- IFIDWre  out  1  IF/ID register write enable
- IFIDFlush  out  1  IF/ID register loads a bubble
- IDEXFlush  out  1  ID/EX register loads a bubble
- EXMEMWre  out  1  EX/MEM register write enable
- MEMWBFlush  out  1  MEM/WB register loads a bubble
- mem_err  out  1  sticky memory timeout flag
- state  out  2  current FSM state (debug)

Behaviour:
- FSM states:
  - RUN = 2'b00
  - STALL = 2'b01
  - MWAIT = 2'b10
  - ERR = 2'b11
- The state register and the wait counter (width clog2(MEM_TIMEOUT+1)) are the only storage. The control outputs are combinational from state and inputs.
- While Reset = 0:
  - state = RUN, counter = 0, mem_err = 0.
  - Outputs forced: PCWre = 0, IFIDWre = 0, EXMEMWre = 0, IFIDFlush = 1, IDEXFlush = 1, MEMWBFlush = 1.
  - Outputs are released immediately when Reset deasserts.
- lu_hazard is true when all of the following hold:
  - ex_Mwk & ex_RegWr & (ex_RegDst == 2'b01) & (ex_rd != 0) & id_valid
  - and at least one of: (id_use_rs1 & id_rs1 == ex_rd), (id_use_rs2 & id_rs2 == ex_rd).
- Decision priority, evaluated each cycle:
  1. MWAIT or ERR.
  2. mem_req & !mem_ready.
  3. ex_branch_taken.
  4. lu_hazard.
  5. Normal flow.
- mem_req & !mem_ready while in RUN or STALL (full freeze):
  - PCWre = 0, IFIDWre = 0, EXMEMWre = 0, MEMWBFlush = 1; no other flushes.
  - Next state MWAIT, counter = 1.
- MWAIT:
  - Same freeze outputs.
  - mem_ready = 1: that cycle behaves as RUN (branch and load-use rules apply to the frozen EX/ID contents); next state RUN; counter cleared.
  - Otherwise the counter increments. When the counter reaches MEM_TIMEOUT with mem_ready still 0, next state is ERR.
- ERR:
  - Full freeze outputs, mem_err = 1.
  - Exit only via Reset.
- ex_branch_taken (not frozen):
  - PCWre = 1 (PC loads the target), IFIDFlush = 1, IDEXFlush = 1, EXMEMWre = 1.
  - Any simultaneous lu_hazard is ignored, because the ID instruction is wrong-path.
  - Next state RUN.
- lu_hazard (not frozen, no branch):
  - PCWre = 0, IFIDWre = 0, IDEXFlush = 1, EXMEMWre = 1.
  - Next state STALL.
  - Exactly one bubble is inserted; the load then sits in MEM and forwarding supplies the data.
- STALL:
  - Outputs are normal flow.
  - A second lu_hazard is impossible because EX holds the bubble. If one is presented anyway, it is handled again as a fresh load-use hazard.
  - Next state RUN.
- Normal flow: PCWre = IFIDWre = EXMEMWre = 1; all flushes 0.
- A register address of 0 never causes a stall.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, two extra outputs are added:
  - stall_cycles (32 bits): counts every cycle with PCWre = 0 outside reset.
  - flush_events (32 bits): counts every cycle with IDEXFlush = 1 caused by a branch.
- Both counters saturate at 32'hFFFFFFFF and reset to 0 asynchronously.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Load x5 in EX with ID add x6,x5,x1 (use_rs1) -> exactly one cycle of PCWre = 0, IFIDWre = 0, IDEXFlush = 1, state = STALL; next cycle state = RUN with normal flow.
- Load with ex_rd = 0 while ID reads x0 -> no stall; normal flow every cycle.
- ex_branch_taken and lu_hazard in the same cycle -> PCWre = 1, IFIDFlush = 1, IDEXFlush = 1, no stall; state stays RUN.
- mem_req = 1 with mem_ready low for 3 cycles and then high -> 3 frozen cycles with MEMWBFlush = 1 and state = MWAIT; on the ready cycle, normal flow and state = RUN.
- MEM_TIMEOUT = 4, mem_ready held low -> state = ERR after the 4th wait cycle, mem_err = 1, stays frozen; Reset pulse low -> all outputs at reset values immediately; after release, state = RUN and mem_err = 0.
- Reset asserted while in MWAIT -> asynchronous return to RUN with counter = 0; with HAZARD_PERF_EN defined, stall_cycles = 0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline hazard-control bundle between the CPU datapath (master) and hazard_ctrl (slave).
//   master drives the ID/EX/MEM status inputs and observes the control outputs;
//   slave (hazard_ctrl) reads the status and drives PC/pipeline-register enables, flushes, mem_err and state.
interface hazard_ctrl_if;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic       ex_Mwk;
    logic       ex_RegWr;
    logic [1:0] ex_RegDst;
    logic [4:0] ex_rd;
    logic       ex_branch_taken;
    logic       mem_req;
    logic       mem_ready;
    logic       PCWre;
    logic       IFIDWre;
    logic       IFIDFlush;
    logic       IDEXFlush;
    logic       EXMEMWre;
    logic       MEMWBFlush;
    logic       mem_err;
    logic [1:0] state;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_Mwk, ex_RegWr, ex_RegDst, ex_rd, ex_branch_taken,
        output mem_req, mem_ready,
        input  PCWre, IFIDWre, IFIDFlush, IDEXFlush, EXMEMWre, MEMWBFlush, mem_err, state
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_Mwk, ex_RegWr, ex_RegDst, ex_rd, ex_branch_taken,
        input  mem_req, mem_ready,
        output PCWre, IFIDWre, IFIDFlush, IDEXFlush, EXMEMWre, MEMWBFlush, mem_err, state
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: five-stage pipeline sequencer handling load-use stalls, taken-branch squashes and memory-wait freezes.
//   CLK          pipeline clock, rising edge
//   Reset        asynchronous active-low reset; forces PC/IFID/EXMEM disabled and all flushes while low
//   hz           hazard_ctrl_if.slave: ID/EX/MEM status in; PCWre, IFIDWre, IFIDFlush, IDEXFlush,
//                EXMEMWre, MEMWBFlush, mem_err (sticky timeout) and state (debug) out
//   stall_cycles / flush_events  performance counters, present only when HAZARD_PERF_EN is defined
//   MEM_TIMEOUT  consecutive mem_ready-low cycles tolerated before locking in ERR (1..255)
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        Reset,
`ifdef HAZARD_PERF_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events,
`endif
    hazard_ctrl_if.slave hz
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, MWAIT = 2'b10, ERR = 2'b11} state_t;

    state_t        cur, nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          lu_hazard, frozen;
    logic          pc_wre, ifid_wre, ifid_flush, idex_flush, exmem_wre, memwb_flush;

    // Only a load in EX whose result the ID instruction needs forces a bubble; x0 is never a dependency.
    assign lu_hazard = hz.ex_Mwk && hz.ex_RegWr && hz.ex_RegDst == 2'b01 && hz.ex_rd != 5'd0 && hz.id_valid &&
                       ((hz.id_use_rs1 && hz.id_rs1 == hz.ex_rd) || (hz.id_use_rs2 && hz.id_rs2 == hz.ex_rd));

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            cur <= RUN;
            cnt <= '0;
        end else begin
            cur <= nxt;
            cnt <= cnt_nxt;
        end
    end

    always_comb begin
        nxt         = cur;
        cnt_nxt     = cnt;
        frozen      = 1'b0;
        pc_wre      = 1'b1;
        ifid_wre    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_wre   = 1'b1;
        memwb_flush = 1'b0;
        if (cur == ERR) begin
            frozen = 1'b1;
        end else if (cur == MWAIT && !hz.mem_ready) begin
            // cnt already counts the cycle that entered MWAIT, so this cycle is wait number cnt+1
            frozen  = 1'b1;
            nxt     = (int'(cnt) >= MEM_TIMEOUT - 1) ? ERR : MWAIT;
            cnt_nxt = cnt + 1'b1;
        end else if (hz.mem_req && !hz.mem_ready) begin
            frozen  = 1'b1;
            nxt     = MWAIT;
            cnt_nxt = CW'(1);
        end else if (hz.ex_branch_taken) begin
            // ID holds a wrong-path instruction, so any load-use match there is irrelevant
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            nxt        = RUN;
            cnt_nxt    = '0;
        end else if (lu_hazard) begin
            pc_wre     = 1'b0;
            ifid_wre   = 1'b0;
            idex_flush = 1'b1;
            nxt        = STALL;
            cnt_nxt    = '0;
        end else begin
            nxt     = RUN;
            cnt_nxt = '0;
        end
        if (frozen) begin
            pc_wre      = 1'b0;
            ifid_wre    = 1'b0;
            exmem_wre   = 1'b0;
            memwb_flush = 1'b1;
        end
        if (!Reset) begin
            pc_wre      = 1'b0;
            ifid_wre    = 1'b0;
            exmem_wre   = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            memwb_flush = 1'b1;
        end
    end

    assign hz.PCWre      = pc_wre;
    assign hz.IFIDWre    = ifid_wre;
    assign hz.IFIDFlush  = ifid_flush;
    assign hz.IDEXFlush  = idex_flush;
    assign hz.EXMEMWre   = exmem_wre;
    assign hz.MEMWBFlush = memwb_flush;
    assign hz.mem_err    = cur == ERR;
    assign hz.state      = cur;

`ifdef HAZARD_PERF_EN
    logic br_flush;

    assign br_flush = !frozen && hz.ex_branch_taken;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!pc_wre && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
            if (br_flush && flush_events != '1) flush_events <= flush_events + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scoreboard bench for hazard_ctrl built with MEM_TIMEOUT = 4.
module tb_hazard_ctrl;
    localparam logic [5:0] NORM = 6'b110010;
    localparam logic [5:0] LU   = 6'b000110;
    localparam logic [5:0] BR   = 6'b111110;
    localparam logic [5:0] FRZ  = 6'b000001;
    localparam logic [5:0] RST  = 6'b001101;

    typedef struct {
        logic [8:0] v;
        string      name;
    } exp_t;

    logic CLK = 1'b0;
    logic Reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];

    hazard_ctrl_if hz ();

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles, flush_events;
    hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .CLK(CLK), .Reset(Reset), .stall_cycles(stall_cycles), .flush_events(flush_events), .hz(hz)
    );
`else
    hazard_ctrl #(.MEM_TIMEOUT(4)) dut (.CLK(CLK), .Reset(Reset), .hz(hz));
`endif

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [8:0] act;
            e   = q.pop_front();
            act = {hz.PCWre, hz.IFIDWre, hz.IFIDFlush, hz.IDEXFlush, hz.EXMEMWre, hz.MEMWBFlush, hz.mem_err, hz.state};
            n_cmp++;
            if (act !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %b expected %b (PCWre IFIDWre IFIDFlush IDEXFlush EXMEMWre MEMWBFlush mem_err state)",
                         e.name, act, e.v);
            end
        end
    end

    task automatic id_set(input logic v, input logic [4:0] r1, input logic [4:0] r2, input logic u1, input logic u2);
        hz.id_valid = v; hz.id_rs1 = r1; hz.id_rs2 = r2; hz.id_use_rs1 = u1; hz.id_use_rs2 = u2;
    endtask

    task automatic ex_set(input logic mwk, input logic rw, input logic [1:0] dst, input logic [4:0] rd, input logic br);
        hz.ex_Mwk = mwk; hz.ex_RegWr = rw; hz.ex_RegDst = dst; hz.ex_rd = rd; hz.ex_branch_taken = br;
    endtask

    task automatic mem_set(input logic req, input logic rdy);
        hz.mem_req = req; hz.mem_ready = rdy;
    endtask

    task automatic idle();
        id_set(0, 0, 0, 0, 0); ex_set(0, 0, 2'b00, 0, 0); mem_set(0, 0);
    endtask

    task automatic tick(input logic [5:0] outs, input logic err, input logic [1:0] st, input string name);
        exp_t e;
        e.v = {outs, err, st}; e.name = name;
        q.push_back(e);
        @(posedge CLK); #1;
    endtask

    initial begin
        Reset = 1'b0;
        idle();
        @(posedge CLK); #1;
        tick(RST, 0, 2'b00, "reset_hold");
        Reset = 1'b1;
        tick(NORM, 0, 2'b00, "idle_run");
        id_set(1, 5, 1, 1, 1); ex_set(1, 1, 2'b01, 5, 0);
        tick(LU, 0, 2'b00, "lu_rs1_stall");
        ex_set(0, 0, 2'b00, 0, 0);
        tick(NORM, 0, 2'b01, "lu_bubble_state_stall");
        tick(NORM, 0, 2'b00, "lu_back_to_run");
        id_set(1, 3, 7, 1, 1); ex_set(1, 1, 2'b01, 7, 0);
        tick(LU, 0, 2'b00, "lu_rs2_stall");
        ex_set(0, 0, 2'b00, 0, 0);
        tick(NORM, 0, 2'b01, "lu_rs2_stall_state");
        id_set(1, 3, 7, 1, 0); ex_set(1, 1, 2'b01, 7, 0);
        tick(NORM, 0, 2'b00, "rs2_not_used");
        id_set(1, 5, 0, 1, 0); ex_set(1, 1, 2'b00, 5, 0);
        tick(NORM, 0, 2'b00, "alu_writer_no_stall");
        id_set(1, 0, 0, 1, 1); ex_set(1, 1, 2'b01, 0, 0);
        tick(NORM, 0, 2'b00, "x0_load_no_stall_a");
        tick(NORM, 0, 2'b00, "x0_load_no_stall_b");
        id_set(0, 5, 0, 1, 0); ex_set(1, 1, 2'b01, 5, 0);
        tick(NORM, 0, 2'b00, "id_invalid_no_stall");
        id_set(1, 5, 0, 1, 0); ex_set(1, 1, 2'b01, 5, 1);
        tick(BR, 0, 2'b00, "branch_beats_lu");
        idle();
        tick(NORM, 0, 2'b00, "after_branch_run");
        mem_set(1, 0);
        tick(FRZ, 0, 2'b00, "mwait_enter");
        tick(FRZ, 0, 2'b10, "mwait_1");
        tick(FRZ, 0, 2'b10, "mwait_2");
        mem_set(1, 1);
        tick(NORM, 0, 2'b10, "mwait_ready");
        idle();
        tick(NORM, 0, 2'b00, "mwait_back_run");
        mem_set(1, 0); ex_set(1, 0, 2'b00, 0, 1);
        tick(FRZ, 0, 2'b00, "freeze_beats_branch");
        mem_set(1, 1);
        tick(BR, 0, 2'b10, "ready_cycle_branch");
        idle();
        tick(NORM, 0, 2'b00, "run_after_ready_branch");
        mem_set(1, 0);
        tick(FRZ, 0, 2'b00, "to_wait_1");
        tick(FRZ, 0, 2'b10, "to_wait_2");
        tick(FRZ, 0, 2'b10, "to_wait_3");
        tick(FRZ, 0, 2'b10, "to_wait_4");
        tick(FRZ, 1, 2'b11, "timeout_err");
        mem_set(1, 1);
        tick(FRZ, 1, 2'b11, "err_sticky");
        Reset = 1'b0;
        tick(RST, 0, 2'b00, "err_async_reset");
        Reset = 1'b1; idle();
        tick(NORM, 0, 2'b00, "err_cleared_run");
        mem_set(1, 0);
        tick(FRZ, 0, 2'b00, "rst_mw_enter");
        tick(FRZ, 0, 2'b10, "rst_mw_wait");
        tick(FRZ, 0, 2'b10, "rst_mw_wait2");
        Reset = 1'b0;
`ifdef HAZARD_PERF_EN
        #1;
        n_cmp++;
        if (stall_cycles !== 32'd0) begin
            n_bad++;
            $display("FAIL perf_reset: stall_cycles got %0d expected 0", stall_cycles);
        end
`endif
        tick(RST, 0, 2'b00, "mwait_async_reset");
        Reset = 1'b1;
        tick(FRZ, 0, 2'b00, "cnt_clear_wait_1");
        tick(FRZ, 0, 2'b10, "cnt_clear_wait_2");
        tick(FRZ, 0, 2'b10, "cnt_clear_wait_3");
        tick(FRZ, 0, 2'b10, "cnt_clear_wait_4");
        tick(FRZ, 1, 2'b11, "cnt_clear_err");
        idle();
        @(negedge CLK); #1;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
